// File: rtl/vram_pkg.sv
// Shared frame-buffer geometry and host FSM encoding for the VRAM arbiter.
// Pure declarations: no logic, no latency.
// Backpressure: not applicable.
package vram_pkg;

  localparam int FB_W     = 160;  // stored pixels per row
  localparam int FB_H     = 120;  // stored rows
  localparam int SCALE_SH = 2;    // log2 of pixel replication on the scan
  localparam int AW       = 15;   // RAM word address width
  localparam int DW       = 8;    // RGB 3-3-2 pixel

  // Host transaction FSM: accept -> RAM cycle -> capture read data -> ack
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } host_state_t;

endpackage

// File: rtl/fb_addr_gen.sv
// Maps a scan position to a frame-buffer word address (row-major, 160 wide).
// Latency: purely combinational.
// Backpressure: none.
module fb_addr_gen #(
  parameter int AW       = vram_pkg::AW,
  parameter int SCALE_SH = vram_pkg::SCALE_SH
) (
  input  logic [9:0]    i_pixel_x,
  input  logic [9:0]    i_pixel_y,
  output logic [AW-1:0] o_addr
);

  logic [AW-1:0] w_x_s;
  logic [AW-1:0] w_y_s;

  // Scale the scan position down to stored-pixel coordinates
  assign w_x_s = AW'(i_pixel_x >> SCALE_SH);
  assign w_y_s = AW'(i_pixel_y >> SCALE_SH);

  // y*160 built from two shifts so no multiplier is needed
  assign o_addr = (w_y_s << 7) + (w_y_s << 5) + w_x_s;

endmodule

// File: rtl/vram_arbiter.sv
// Shares one single-port frame-buffer RAM between the display scan and a host port.
// Latency: pixel tick to rgb 3 clk; host accept to ack 3 clk (4 if a display slot collides).
// Backpressure: display always wins the RAM; host req is held until ack, stalled at most 1 clk.
module vram_arbiter #(
  parameter int FB_W     = vram_pkg::FB_W,
  parameter int FB_H     = vram_pkg::FB_H,
  parameter int SCALE_SH = vram_pkg::SCALE_SH,
  parameter int AW       = vram_pkg::AW,
  parameter int DW       = vram_pkg::DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          utick,
  input  logic          video_on,
  input  logic [9:0]    pixel_x,
  input  logic [9:0]    pixel_y,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ack,
  output logic [DW-1:0] host_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [DW-1:0] rgb,
  output logic          hsync_out,
  output logic          vsync_out
);

  import vram_pkg::*;

  localparam logic [AW-1:0] FB_WORDS = AW'(FB_W * FB_H);

  host_state_t   r_state;
  host_state_t   w_state_nxt;
  logic          w_accept;
  logic          w_disp_slot;
  logic          w_host_inrange;
  logic [AW-1:0] w_disp_addr;

  logic          r_ram_en;
  logic          r_ram_we;
  logic [AW-1:0] r_ram_addr;
  logic [DW-1:0] r_ram_wdata;

  logic          r_h_rd;        // in-flight host op is an in-range read
  logic          r_host_ack;
  logic [DW-1:0] r_host_rdata;

  logic          r_t1_vld;      // tick tag while its RAM cycle runs
  logic          r_t1_on;
  logic          r_t2_vld;      // tick tag while its read data is on ram_rdata
  logic          r_t2_on;
  logic [DW-1:0] r_rgb;
  logic [2:0]    r_hs_dly;
  logic [2:0]    r_vs_dly;

  assign w_disp_slot    = utick & video_on;
  assign w_host_inrange = (host_addr < FB_WORDS);

  fb_addr_gen #(
    .AW       (AW),
    .SCALE_SH (SCALE_SH)
  ) u_fb_addr_gen (
    .i_pixel_x (pixel_x),
    .i_pixel_y (pixel_y),
    .o_addr    (w_disp_addr)
  );

  // Host FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Host FSM next state; a claimed display slot simply defers acceptance one clk
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (host_req && !w_disp_slot) begin
          w_accept    = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE:   w_state_nxt = WAIT;
      WAIT:    w_state_nxt = ACK;
      ACK:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // RAM command register: display read, else accepted host op (out-of-range ops never enable)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
    end else begin
      r_ram_en <= 1'b0;
      r_ram_we <= 1'b0;
      if (w_disp_slot) begin
        r_ram_en   <= 1'b1;
        r_ram_addr <= w_disp_addr;
      end else if (w_accept) begin
        r_ram_en    <= w_host_inrange;
        r_ram_we    <= host_we & w_host_inrange;
        r_ram_addr  <= host_addr;
        r_ram_wdata <= host_wdata;
      end
    end
  end

  // Host response: capture read data in WAIT, pulse ack in the following clk
  always_ff @(posedge clk) begin
    if (reset) begin
      r_h_rd       <= 1'b0;
      r_host_ack   <= 1'b0;
      r_host_rdata <= '0;
    end else begin
      if (w_accept) r_h_rd <= ~host_we & w_host_inrange;
      r_host_ack <= (r_state == WAIT);
      if (r_state == WAIT) r_host_rdata <= r_h_rd ? ram_rdata : '0;
    end
  end

  // Display pipe: tick tag follows its RAM read, rgb loads when the data arrives
  always_ff @(posedge clk) begin
    if (reset) begin
      r_t1_vld <= 1'b0;
      r_t1_on  <= 1'b0;
      r_t2_vld <= 1'b0;
      r_t2_on  <= 1'b0;
      r_rgb    <= '0;
    end else begin
      r_t1_vld <= utick;
      r_t1_on  <= video_on;
      r_t2_vld <= r_t1_vld;
      r_t2_on  <= r_t1_on;
      if (r_t2_vld) r_rgb <= r_t2_on ? ram_rdata : '0;
    end
  end

  // Sync delay lines matched to the 3-clk pixel path
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hs_dly <= '0;
      r_vs_dly <= '0;
    end else begin
      r_hs_dly <= {r_hs_dly[1:0], hsync_in};
      r_vs_dly <= {r_vs_dly[1:0], vsync_in};
    end
  end

  assign ram_en     = r_ram_en;
  assign ram_we     = r_ram_we;
  assign ram_addr   = r_ram_addr;
  assign ram_wdata  = r_ram_wdata;
  assign host_ack   = r_host_ack;
  assign host_rdata = r_host_rdata;
  assign rgb        = r_rgb;
  assign hsync_out  = r_hs_dly[2];
  assign vsync_out  = r_vs_dly[2];

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter with a behavioural single-port RAM.
// Stimulus pushes expected RAM cycles, acks, rgb and sync values; a negedge monitor checks them.
// Host requests are held until ack and dropped in the ack cycle.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        utick = 1'b0;
  logic        video_on = 1'b0;
  logic [9:0]  pixel_x = '0;
  logic [9:0]  pixel_y = '0;
  logic        hsync_in = 1'b0;
  logic        vsync_in = 1'b0;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [14:0] host_addr = '0;
  logic [7:0]  host_wdata = '0;
  logic        host_ack;
  logic [7:0]  host_rdata;
  logic        ram_en;
  logic        ram_we;
  logic [14:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = '0;
  logic [7:0]  rgb;
  logic        hsync_out;
  logic        vsync_out;

  vram_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .utick      (utick),
    .video_on   (video_on),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .rgb        (rgb),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural synchronous single-port RAM
  logic [7:0] mem [0:32767];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  typedef struct { int cyc; bit we; logic [14:0] addr; logic [7:0] wdata; } ram_exp_t;
  typedef struct { int cyc; bit rd; logic [7:0] rdata; } ack_exp_t;
  typedef struct { int cyc; logic [7:0] val; } val_exp_t;

  ram_exp_t q_ram [$];
  ack_exp_t q_ack [$];
  val_exp_t q_rgb [$];
  val_exp_t q_sync [$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares DUT outputs against the scoreboard away from the active edge
  ram_exp_t re;
  ack_exp_t ae;
  val_exp_t ve;
  always @(negedge clk) begin
    if (cyc >= 1) begin
      chk("ram_we_without_en", int'(ram_we & ~ram_en), 0);
      if (ram_en) begin
        if (q_ram.size() == 0) chk("ram_unexpected_en", int'(ram_en), 0);
        else begin
          re = q_ram.pop_front();
          chk("ram_cycle", cyc, re.cyc);
          chk("ram_we", int'(ram_we), int'(re.we));
          chk("ram_addr", int'(ram_addr), int'(re.addr));
          if (re.we) chk("ram_wdata", int'(ram_wdata), int'(re.wdata));
        end
      end
      if (q_ram.size() > 0 && q_ram[0].cyc < cyc) begin
        re = q_ram.pop_front();
        chk("ram_missing_cycle", cyc, re.cyc);
      end
      if (host_ack) begin
        if (q_ack.size() == 0) chk("ack_unexpected", int'(host_ack), 0);
        else begin
          ae = q_ack.pop_front();
          chk("ack_cycle", cyc, ae.cyc);
          if (ae.rd) chk("host_rdata", int'(host_rdata), int'(ae.rdata));
        end
      end
      if (q_ack.size() > 0 && q_ack[0].cyc < cyc) begin
        ae = q_ack.pop_front();
        chk("ack_missing_cycle", cyc, ae.cyc);
      end
      while (q_rgb.size() > 0 && q_rgb[0].cyc <= cyc) begin
        ve = q_rgb.pop_front();
        chk("rgb", int'(rgb), int'(ve.val));
      end
      while (q_sync.size() > 0 && q_sync[0].cyc <= cyc) begin
        ve = q_sync.pop_front();
        chk("hsync_vsync", int'({hsync_out, vsync_out}), int'(ve.val));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for host_ack and drops req in the ack cycle
  task automatic wait_ack();
    bit got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      step();
      if (host_ack) got = 1'b1;
    end
    host_req = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout cyc=%0d got=no_ack expected=ack", cyc);
    end
  endtask

  // Unstalled host transaction: RAM cycle at req+1 (if in range), ack at req+3
  task automatic host_txn(input bit we, input logic [14:0] addr, input logic [7:0] wdata,
                          input bit exp_ram, input logic [7:0] exp_rdata);
    int c;
    step();
    host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wdata;
    c = cyc;
    if (exp_ram) q_ram.push_back('{cyc: c + 1, we: we, addr: addr, wdata: wdata});
    q_ack.push_back('{cyc: c + 3, rd: !we, rdata: exp_rdata});
    wait_ack();
  endtask

  // One pixel tick followed by three idle clocks
  task automatic tick(input bit vid, input int x, input int y,
                      input logic [14:0] exp_addr, input logic [7:0] exp_rgb);
    int c;
    step();
    utick = 1'b1; video_on = vid; pixel_x = 10'(x); pixel_y = 10'(y);
    c = cyc;
    if (vid) q_ram.push_back('{cyc: c + 1, we: 1'b0, addr: exp_addr, wdata: 8'h00});
    q_rgb.push_back('{cyc: c + 3, val: exp_rgb});
    step(); utick = 1'b0;
    step();
    step();
  endtask

  initial begin
    int c;
    for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
    mem[19200 % 32768] = 8'hFF;

    // Reset held 10 clk; outputs at reset values in the first clk after release
    repeat (10) step();
    reset = 1'b0;
    chk("rst_host_ack", int'(host_ack), 0);
    chk("rst_host_rdata", int'(host_rdata), 0);
    chk("rst_ram_en", int'(ram_en), 0);
    chk("rst_ram_we", int'(ram_we), 0);
    chk("rst_ram_addr", int'(ram_addr), 0);
    chk("rst_ram_wdata", int'(ram_wdata), 0);
    chk("rst_rgb", int'(rgb), 0);
    chk("rst_hsync_out", int'(hsync_out), 0);
    chk("rst_vsync_out", int'(vsync_out), 0);

    // Blanking ticks: no RAM cycle, rgb 0
    tick(1'b0, 700, 10, 15'd0, 8'h00);
    tick(1'b0, 0, 490, 15'd0, 8'h00);

    // Sync alignment: hsync pulse then vsync pulse, each seen 3 clk later
    step();
    hsync_in = 1'b1; c = cyc;
    q_sync.push_back('{cyc: c + 2, val: 8'h0});
    q_sync.push_back('{cyc: c + 3, val: 8'h2});
    step();
    hsync_in = 1'b0; vsync_in = 1'b1;
    q_sync.push_back('{cyc: c + 4, val: 8'h1});
    step();
    vsync_in = 1'b0;
    q_sync.push_back('{cyc: c + 5, val: 8'h0});
    repeat (3) step();

    // Host write then read of address 0 during blanking
    host_txn(1'b1, 15'd0, 8'hE0, 1'b1, 8'h00);
    host_txn(1'b0, 15'd0, 8'h00, 1'b1, 8'hE0);

    // Scan pixels (0,0)..(3,3) all map to address 0
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++)
        tick(1'b1, x, y, 15'd0, 8'hE0);

    // Host request in the same clk as a display slot: display first, ack 4 clk later
    step();
    utick = 1'b1; video_on = 1'b1; pixel_x = 10'd2; pixel_y = 10'd1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 15'd0;
    c = cyc;
    q_ram.push_back('{cyc: c + 1, we: 1'b0, addr: 15'd0, wdata: 8'h00});
    q_rgb.push_back('{cyc: c + 3, val: 8'hE0});
    q_ram.push_back('{cyc: c + 2, we: 1'b0, addr: 15'd0, wdata: 8'h00});
    q_ack.push_back('{cyc: c + 4, rd: 1'b1, rdata: 8'hE0});
    step();
    utick = 1'b0;
    wait_ack();

    // Address mapping: (5,6) -> 161, (639,479) -> 19199, (100,37) -> 1465
    host_txn(1'b1, 15'd161, 8'h1C, 1'b1, 8'h00);
    tick(1'b1, 5, 6, 15'd161, 8'h1C);
    host_txn(1'b1, 15'd19199, 8'h5A, 1'b1, 8'h00);
    tick(1'b1, 639, 479, 15'd19199, 8'h5A);
    host_txn(1'b1, 15'd1465, 8'h33, 1'b1, 8'h00);
    tick(1'b1, 100, 37, 15'd1465, 8'h33);

    // Out-of-range host ops: acked, no RAM cycle, read returns 0
    host_txn(1'b1, 15'd19200, 8'hAB, 1'b0, 8'h00);
    host_txn(1'b0, 15'd19200, 8'h00, 1'b0, 8'h00);
    host_txn(1'b0, 15'd32767, 8'h00, 1'b0, 8'h00);

    // Blank tick clears rgb, then a visible one restores E0
    tick(1'b0, 0, 0, 15'd0, 8'h00);
    tick(1'b1, 0, 0, 15'd0, 8'hE0);

    // Reset during WAIT: RAM write already issued, no ack afterwards
    step();
    host_req = 1'b1; host_we = 1'b1; host_addr = 15'd5; host_wdata = 8'h77;
    c = cyc;
    q_ram.push_back('{cyc: c + 1, we: 1'b1, addr: 15'd5, wdata: 8'h77});
    step();
    step();
    reset = 1'b1; host_req = 1'b0;
    step();
    reset = 1'b0;
    chk("post_rst_host_ack", int'(host_ack), 0);
    chk("post_rst_rgb", int'(rgb), 0);
    chk("post_rst_ram_en", int'(ram_en), 0);
    repeat (4) step();

    // FSM back in IDLE: a read is accepted immediately and sees the earlier write
    host_txn(1'b0, 15'd5, 8'h00, 1'b1, 8'h77);

    repeat (8) step();
    chk("q_ram_drained", q_ram.size(), 0);
    chk("q_ack_drained", q_ack.size(), 0);
    chk("q_rgb_drained", q_rgb.size(), 0);
    chk("q_sync_drained", q_sync.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "simulation time limit reached");
  end

endmodule
